hard_demapper: RTL and testbench

//  Hard-decision demapper: receive-side counterpart of the mapper. Accepts one

---
 rtl/hard_demapper.sv | 151 +++++++++++++++
 tb/tb_hard_demapper.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hard_demapper.sv
// Hard-decision demapper: slices one signed I/Q symbol per handshake for the
// selected modulation scheme and packs the recovered bits into output words.
module hard_demapper #(
  parameter int unsigned             SYMBOL_WIDTH    = 16,
  parameter int unsigned             DATA_WIDTH      = 12,
  parameter int unsigned             SCHEME_WIDTH    = 4,
  parameter logic [SYMBOL_WIDTH-1:0] QAM16_AMPLITUDE = 16'b0010100001111010,
  parameter logic [SYMBOL_WIDTH-1:0] QAM64_AMPLITUDE = 16'b0001001111000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic signed [SYMBOL_WIDTH-1:0] sym_i,
  input  logic signed [SYMBOL_WIDTH-1:0] sym_q,
  input  logic        [SCHEME_WIDTH-1:0] scheme,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic        [DATA_WIDTH-1:0]   data_out,
  output logic        [SCHEME_WIDTH-1:0] data_scheme,
  output logic                           err_scheme
);

  localparam int unsigned MW = SYMBOL_WIDTH + 2;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  localparam logic [SCHEME_WIDTH-1:0] SCH_PB2   = SCHEME_WIDTH'(1);
  localparam logic [SCHEME_WIDTH-1:0] SCH_BPSK  = SCHEME_WIDTH'(2);
  localparam logic [SCHEME_WIDTH-1:0] SCH_QPSK  = SCHEME_WIDTH'(3);
  localparam logic [SCHEME_WIDTH-1:0] SCH_QAM16 = SCHEME_WIDTH'(4);
  localparam logic [SCHEME_WIDTH-1:0] SCH_QAM64 = SCHEME_WIDTH'(5);

  // Decision thresholds, held at the widened magnitude width
  localparam logic [MW-1:0] A16_X2 = MW'({2'b00, QAM16_AMPLITUDE} << 1);
  localparam logic [MW-1:0] A64_X2 = MW'({2'b00, QAM64_AMPLITUDE} << 1);
  localparam logic [MW-1:0] A64_X4 = MW'({2'b00, QAM64_AMPLITUDE} << 2);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                  state;
  logic [CW-1:0]           count;
  logic [SCHEME_WIDTH-1:0] cur_scheme;
  logic [DATA_WIDTH-1:0]   acc;

  logic                    i_sign, q_sign;
  logic [MW-1:0]           i_ext, q_ext, i_mag, q_mag;
  logic [MW-1:0]           i_dif, q_dif, i_dmag, q_dmag;
  logic                    i_gt16, q_gt16, i_gt64, q_gt64, i_in64, q_in64;
  logic [SCHEME_WIDTH-1:0] eff_scheme;
  logic                    supported;
  logic [CW-1:0]           spw;
  logic [DATA_WIDTH-1:0]   acc_next;

  assign s_ready = (state == COLLECT) && !flush;

  // Magnitudes at SYMBOL_WIDTH+2 bits so the most negative input negates cleanly
  always_comb begin
    i_sign = sym_i[SYMBOL_WIDTH-1];
    q_sign = sym_q[SYMBOL_WIDTH-1];
    i_ext  = {{2{i_sign}}, sym_i};
    q_ext  = {{2{q_sign}}, sym_q};
    i_mag  = i_sign ? (~i_ext + MW'(1)) : i_ext;
    q_mag  = q_sign ? (~q_ext + MW'(1)) : q_ext;
    i_dif  = i_mag - A64_X4;
    q_dif  = q_mag - A64_X4;
    i_dmag = i_dif[MW-1] ? (~i_dif + MW'(1)) : i_dif;
    q_dmag = q_dif[MW-1] ? (~q_dif + MW'(1)) : q_dif;
    i_gt16 = i_mag > A16_X2;
    q_gt16 = q_mag > A16_X2;
    i_gt64 = i_mag > A64_X4;
    q_gt64 = q_mag > A64_X4;
    i_in64 = i_dmag > A64_X2;
    q_in64 = q_dmag > A64_X2;
  end

  // Scheme is taken from the port only on the first symbol of a word
  always_comb begin
    eff_scheme = (count == '0) ? scheme : cur_scheme;
    supported  = 1'b1;
    spw        = CW'(DATA_WIDTH);
    acc_next   = acc;
    case (eff_scheme)
      SCH_PB2:  acc_next = {acc[DATA_WIDTH-2:0], (count[0] ? q_sign : i_sign)};
      SCH_BPSK: acc_next = {acc[DATA_WIDTH-2:0], i_sign};
      SCH_QPSK: begin
        spw      = CW'(DATA_WIDTH / 2);
        acc_next = {acc[DATA_WIDTH-3:0], i_sign, q_sign};
      end
      SCH_QAM16: begin
        spw      = CW'(DATA_WIDTH / 4);
        acc_next = {acc[DATA_WIDTH-5:0], i_sign, q_sign, i_gt16, q_gt16};
      end
      SCH_QAM64: begin
        spw      = CW'(DATA_WIDTH / 6);
        acc_next = {acc[DATA_WIDTH-7:0], i_sign, q_sign, i_gt64, q_gt64,
                    i_in64, q_in64};
      end
      default: supported = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      count       <= '0;
      cur_scheme  <= '0;
      acc         <= '0;
      m_valid     <= 1'b0;
      data_out    <= '0;
      data_scheme <= '0;
      err_scheme  <= 1'b0;
    end else begin
      err_scheme <= 1'b0;
      case (state)
        COLLECT: begin
          if (flush) begin
            count <= '0;
            acc   <= '0;
          end else if (s_valid) begin
            if (!supported) begin
              err_scheme <= 1'b1;
            end else begin
              if (count == '0) cur_scheme <= scheme;
              count <= count + CW'(1);
              if (count == spw - CW'(1)) begin
                data_out    <= acc_next;
                data_scheme <= eff_scheme;
                m_valid     <= 1'b1;
                acc         <= '0;
                state       <= HOLD;
              end else begin
                acc <= acc_next;
              end
            end
          end
        end
        HOLD: begin
          // flush has no effect here; the pending word must drain
          if (m_ready) begin
            m_valid <= 1'b0;
            count   <= '0;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_hard_demapper.sv
// Directed bench for hard_demapper: hand-computed words for every scheme,
// thresholds, backpressure, scheme errors, flush and reset behaviour.
module tb_hard_demapper;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] sym_i;
  logic signed [15:0] sym_q;
  logic [3:0]         scheme;
  logic               m_valid;
  logic               m_ready;
  logic [11:0]        data_out;
  logic [3:0]         data_scheme;
  logic               err_scheme;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic signed [15:0] AB  = 16'sd23170;
  localparam logic signed [15:0] AQ  = 16'sd16384;
  localparam logic signed [15:0] A16 = 16'sd10362;

  hard_demapper dut (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .sym_i(sym_i), .sym_q(sym_q), .scheme(scheme), .m_valid(m_valid),
    .m_ready(m_ready), .data_out(data_out), .data_scheme(data_scheme),
    .err_scheme(err_scheme)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic signed [15:0] i, input logic signed [15:0] q,
                      input logic [3:0] sch);
    sym_i   = i;
    sym_q   = q;
    scheme  = sch;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Sends the first n bits of 'bits' (MSB first) as BPSK symbols
  task automatic send_bpsk(input logic [11:0] bits, input int n);
    for (int k = 0; k < n; k++)
      send(bits[11-k] ? -AB : AB, 16'sd0, 4'd2);
  endtask

  task automatic expect_word(input string tag, input logic [11:0] exp_d,
                             input logic [3:0] exp_s);
    int waited = 0;
    while (!m_valid && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_data"}, 32'(data_out), 32'(exp_d));
    check({tag, "_scheme"}, 32'(data_scheme), 32'(exp_s));
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check({tag, "_drain"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    sym_i = '0; sym_q = '0; scheme = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_scheme", 32'(data_scheme), 32'd0);
    check("rst_err", 32'(err_scheme), 32'd0);
    rst = 1'b0;

    // BPSK with latency check around the 12th symbol
    send_bpsk(12'hAAA, 11);
    check("bpsk_no_early_valid", 32'(m_valid), 32'd0);
    send(AB, 16'sd0, 4'd2);
    check("bpsk_latency", 32'(m_valid), 32'd1);
    check("bpsk_s_ready_hold", 32'(s_ready), 32'd0);
    expect_word("bpsk", 12'hAAA, 4'd2);

    // PB2_BPSK alternates I and Q sign decisions
    for (int k = 0; k < 12; k++) send(-AB, AB, 4'd1);
    expect_word("pb2", 12'hAAA, 4'd1);

    send(-AQ, AQ, 4'd3); send(-AQ, -AQ, 4'd3); send(AQ, -AQ, 4'd3);
    send(-AQ, -AQ, 4'd3); send(AQ, -AQ, 4'd3); send(-AQ, -AQ, 4'd3);
    expect_word("qpsk", 12'hB77, 4'd3);

    send(A16, -16'sd31086, 4'd4); send(-16'sd31086, A16, 4'd4);
    send(A16, -16'sd31086, 4'd4);
    expect_word("qam16", 12'b0101_1010_0101, 4'd4);

    // QAM16 thresholds: exactly 2A is inner, 2A+1 is outer
    send(16'sd20724, 16'sd0, 4'd4); send(16'sd20725, 16'sd0, 4'd4);
    send(-16'sd20724, -16'sd20725, 4'd4);
    expect_word("qam16_thr", 12'h02D, 4'd4);

    send(-16'sd32768, 16'sd15168, 4'd5); send(-16'sd32768, 16'sd15168, 4'd5);
    expect_word("qam64", 12'hAAA, 4'd5);

    // QAM64 thresholds: |I|==4A and ||Q|-4A|==2A are inner decisions
    send(16'sd20224, -16'sd10112, 4'd5); send(16'sd30337, -16'sd1, 4'd5);
    expect_word("qam64_thr", 12'h41B, 4'd5);

    // Backpressure: word must stay put and input must stall
    send_bpsk(12'h555, 12);
    for (int c = 0; c < 10; c++) begin
      check("bp_s_ready", 32'(s_ready), 32'd0);
      check("bp_data", 32'(data_out), 32'h555);
      check("bp_valid", 32'(m_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    expect_word("bp", 12'h555, 4'd2);

    // Scheme change mid-word is ignored
    send(-AQ, AQ, 4'd3); send(-AQ, -AQ, 4'd5); send(AQ, -AQ, 4'd2);
    send(-AQ, -AQ, 4'd7); send(AQ, -AQ, 4'd4); send(-AQ, -AQ, 4'd1);
    expect_word("mid_scheme", 12'hB77, 4'd3);

    // Unsupported scheme: pulse and drop
    send(-AB, 16'sd0, 4'd7);
    check("err_pulse", 32'(err_scheme), 32'd1);
    @(posedge clk);
    #1;
    check("err_one_cycle", 32'(err_scheme), 32'd0);

    // Flush after 3 symbols; symbol offered during flush is refused
    send_bpsk(12'hFFF, 3);
    flush = 1'b1;
    sym_i = -AB; scheme = 4'd2; s_valid = 1'b1;
    #1;
    check("flush_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; s_valid = 1'b0;
    send_bpsk(12'h003, 11);
    check("flush_no_early_valid", 32'(m_valid), 32'd0);
    send_bpsk(12'h003 << 11, 1);
    expect_word("flush", 12'h003, 4'd2);

    // Flush during HOLD is ignored
    send_bpsk(12'h3C3, 12);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    expect_word("hold_flush", 12'h3C3, 4'd2);

    // Reset mid-HOLD drops the pending word at once
    send_bpsk(12'h0F0, 12);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_hold_valid", 32'(m_valid), 32'd0);
    check("rst_hold_data", 32'(data_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_valid", 32'(m_valid), 32'd0);
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
    send_bpsk(12'h5A5, 12);
    expect_word("post_rst", 12'h5A5, 4'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
